// File: rtl/interrupt_button_if.sv
// Avalon-MM slave bus bundle for the button/switch input PIO.
// Signal names follow the Avalon port names used on the system bus.
interface interrupt_button_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/interrupt_button.sv
// Input PIO: 2-FF sync, per-bit debounce, sticky edge capture, masked level irq.
// Zero-latency reads; EDGE register is write-one-to-clear.
module interrupt_button #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    interrupt_button_if.slave s1
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] event_w;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic [WIDTH-1:0][CW-1:0] cnt_d;
    logic             wr;
    logic [31:0]      rdata;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == LAST) begin
                cnt_d[i]    = '0;
                stable_d[i] = sync2_q[i];
                accept[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Event polarity is taken from the newly accepted level.
    always_comb begin
        if (EDGE_TYPE == 0) begin
            event_w = accept & stable_d;
        end else if (EDGE_TYPE == 1) begin
            event_w = accept & ~stable_d;
        end else begin
            event_w = accept;
        end
    end

    always_comb begin
        wr     = s1.chipselect & ~s1.write_n;
        clr    = '0;
        mask_d = mask_q;
        if (wr && s1.address == 2'd3) begin
            clr = s1.writedata[WIDTH-1:0];
        end
        if (wr && s1.address == 2'd2) begin
            mask_d = s1.writedata[WIDTH-1:0];
        end
        // A capture on the same edge as its clear must survive.
        edge_d = (edge_q & ~clr) | event_w;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (s1.address)
            2'd0:    rdata[WIDTH-1:0] = stable_q;
            2'd2:    rdata[WIDTH-1:0] = mask_q;
            2'd3:    rdata[WIDTH-1:0] = edge_q;
            default: rdata = '0;
        endcase
    end

    assign s1.readdata = rdata;
    assign s1.irq      = |(edge_q & mask_q);

    if (WIDTH < 32) begin : g_unused
        logic unused_wd;
        assign unused_wd = ^s1.writedata[31:WIDTH];
    end
endmodule

// File: tb/tb_interrupt_button.sv
// Bench: three PIO instances (different debounce/edge settings) on a shared bus,
// checked every cycle against a history-window model plus directed literals.
module tb_interrupt_button;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  in_port;
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [31:0] rdv [NI];
    logic        irqv [NI];
    bit          cmp_en;
    int          checks = 0;
    int          errors = 0;

    int dcy [NI] = '{1, 8, 3};
    int ety [NI] = '{0, 2, 1};

    logic [3:0] m_st   [NI];
    logic [3:0] m_cap  [NI];
    logic [3:0] m_mask [NI];
    logic [3:0] hist [$];

    always #5 clk = ~clk;

    interrupt_button_if bus0 ();
    interrupt_button_if bus1 ();
    interrupt_button_if bus2 ();

    assign bus0.address = addr;
    assign bus0.chipselect = cs;
    assign bus0.write_n = wn;
    assign bus0.writedata = wd;
    assign bus1.address = addr;
    assign bus1.chipselect = cs;
    assign bus1.write_n = wn;
    assign bus1.writedata = wd;
    assign bus2.address = addr;
    assign bus2.chipselect = cs;
    assign bus2.write_n = wn;
    assign bus2.writedata = wd;
    assign rdv[0] = bus0.readdata;
    assign rdv[1] = bus1.readdata;
    assign rdv[2] = bus2.readdata;
    assign irqv[0] = bus0.irq;
    assign irqv[1] = bus1.irq;
    assign irqv[2] = bus2.irq;

    interrupt_button #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .s1(bus0.slave));
    interrupt_button #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .s1(bus1.slave));
    interrupt_button #(.WIDTH(4), .DEBOUNCE_CYCLES(3), .EDGE_TYPE(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .s1(bus2.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic mclear();
        for (int n = 0; n < NI; n++) begin
            m_st[n] = 4'h0;
            m_cap[n] = 4'h0;
            m_mask[n] = 4'h0;
        end
        hist.delete();
        repeat (12) hist.push_back(4'h0);
    endtask

    function automatic logic [31:0] mexp(input int n, input logic [1:0] a);
        case (a)
            2'd0: return {28'h0, m_st[n]};
            2'd2: return {28'h0, m_mask[n]};
            2'd3: return {28'h0, m_cap[n]};
            default: return 32'h0;
        endcase
    endfunction

    // Model: a level is accepted once the synchronised input (input two edges
    // earlier) has disagreed with the accepted level for the last D edges.
    initial begin
        logic [3:0] ev;
        logic [3:0] clr;
        logic acc;
        mclear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mclear();
            end else begin
                for (int n = 0; n < NI; n++) begin
                    ev = 4'h0;
                    for (int b = 0; b < 4; b++) begin
                        acc = 1'b1;
                        for (int j = 0; j < dcy[n]; j++)
                            if (hist[hist.size() - 2 - j][b] == m_st[n][b]) acc = 1'b0;
                        if (acc) begin
                            m_st[n][b] = ~m_st[n][b];
                            ev[b] = (ety[n] == 2) || (m_st[n][b] == (ety[n] == 0));
                        end
                    end
                    clr = (cs && !wn && addr == 2'd3) ? wd[3:0] : 4'h0;
                    m_cap[n] = (m_cap[n] & ~clr) | ev;
                    if (cs && !wn && addr == 2'd2) m_mask[n] = wd[3:0];
                end
                hist.push_back(in_port);
                if (hist.size() > 12) void'(hist.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int n = 0; n < NI; n++) begin
                    chk($sformatf("cyc_rd%0d_a%0d", n, addr), rdv[n], mexp(n, addr));
                    chk($sformatf("cyc_irq%0d", n), {31'h0, irqv[n]},
                        {31'h0, |(m_cap[n] & m_mask[n])});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1;
        wn = 1'b0;
        addr = a;
        wd = d;
        tick();
        cs = 1'b0;
        wn = 1'b1;
    endtask

    task automatic look(input int n, input logic [1:0] a, input logic [31:0] e, input string nm);
        addr = a;
        #2;
        chk(nm, rdv[n], e);
        chk({nm, "_model"}, mexp(n, a), e);
        tick();
    endtask

    task automatic lookirq(input int n, input logic e, input string nm);
        #2;
        chk(nm, {31'h0, irqv[n]}, {31'h0, e});
        tick();
    endtask

    initial begin
        int b;
        reset_n = 1'b0;
        in_port = 4'h0;
        addr = 2'd0;
        cs = 1'b0;
        wn = 1'b1;
        wd = 32'h0;
        cmp_en = 1'b1;
        repeat (4) tick();
        reset_n = 1'b1;
        tick();

        for (int n = 0; n < NI; n++) begin
            for (int a = 0; a < 4; a++)
                look(n, 2'(a), 32'h0, $sformatf("reset_rd%0d_a%0d", n, a));
            lookirq(n, 1'b0, $sformatf("reset_irq%0d", n));
        end

        addr = 2'd0;
        in_port = 4'h1;
        tick();
        tick();
        look(0, 2'd0, 32'h0, "d1_data_early");
        look(0, 2'd0, 32'h1, "d1_data_k2");
        look(0, 2'd3, 32'h1, "d1_edge");
        wr(2'd2, 32'h1);
        lookirq(0, 1'b1, "d1_irq");
        in_port = 4'h0;
        repeat (12) tick();
        wr(2'd3, 32'hF);
        wr(2'd2, 32'h0);

        in_port = 4'h2;
        repeat (5) tick();
        in_port = 4'h0;
        repeat (14) tick();
        look(1, 2'd0, 32'h0, "d8_glitch_data");
        look(1, 2'd3, 32'h0, "d8_glitch_edge");
        addr = 2'd0;
        in_port = 4'h2;
        repeat (9) tick();
        look(1, 2'd0, 32'h0, "d8_data_early");
        look(1, 2'd0, 32'h2, "d8_data_k9");
        tick();
        in_port = 4'h0;
        look(1, 2'd3, 32'h2, "d8_edge");
        repeat (14) tick();

        wr(2'd3, 32'hF);
        wr(2'd2, 32'h0);
        in_port = 4'h3;
        repeat (4) tick();
        look(0, 2'd3, 32'h3, "w1c_pend");
        wr(2'd2, 32'h1);
        lookirq(0, 1'b1, "w1c_irq_m1");
        wr(2'd3, 32'h1);
        look(0, 2'd3, 32'h2, "w1c_edge");
        lookirq(0, 1'b0, "w1c_irq_clr");
        wr(2'd2, 32'h2);
        lookirq(0, 1'b1, "w1c_irq_m2");

        in_port = 4'h7;
        tick();
        tick();
        wr(2'd3, 32'h4);
        look(0, 2'd3, 32'h6, "set_wins");
        repeat (10) tick();

        wr(2'd3, 32'hF);
        in_port = 4'hF;
        repeat (10) tick();
        look(2, 2'd3, 32'h0, "fall_press");
        in_port = 4'h7;
        repeat (10) tick();
        look(2, 2'd3, 32'h8, "fall_release");
        wr(2'd2, 32'hF);
        addr = 2'd3;
        lookirq(0, 1'b1, "pre_reset_irq");
        in_port = 4'h0;
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        for (int n = 0; n < NI; n++) begin
            chk($sformatf("async_rd%0d", n), rdv[n], 32'h0);
            chk($sformatf("async_irq%0d", n), {31'h0, irqv[n]}, 32'h0);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) begin
                b = $urandom_range(3);
                in_port[b] = ~in_port[b];
            end
            addr = 2'($urandom_range(3));
            cs = ($urandom_range(4) == 0);
            wn = ($urandom_range(2) == 0);
            wd = $urandom;
            if (i == 1500) reset_n = 1'b0;
            if (i == 1502) reset_n = 1'b1;
            tick();
        end
        cs = 1'b0;
        wn = 1'b1;
        tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
